// File: rtl/pred_update_queue_if.sv
// rtl/pred_update_queue_if.sv - commit/update/counter signal bundle for pred_update_queue
interface pred_update_queue_if;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_taken;
   logic        commit_pred;
   logic        commit_ready;
   logic        upd_hold;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_jump;
   logic [31:0] br_total;
   logic [31:0] br_miss;

   modport master (
      output commit_valid, commit_pc, commit_taken, commit_pred, upd_hold,
      input  commit_ready, upd_valid, upd_pc, upd_jump, br_total, br_miss
   );

   modport slave (
      input  commit_valid, commit_pc, commit_taken, commit_pred, upd_hold,
      output commit_ready, upd_valid, upd_pc, upd_jump, br_total, br_miss
   );
endinterface

// File: rtl/pred_update_queue.sv
// rtl/pred_update_queue.sv - 8-entry FIFO buffering committed branch outcomes for predictor update
module pred_update_queue (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   pred_update_queue_if.slave   bus
);
   localparam int DEPTH = 8;

   logic [32:0] mem_q [DEPTH];
   logic [32:0] mem_d [DEPTH];
   logic [2:0]  head_q, head_d;
   logic [2:0]  tail_q, tail_d;
   logic [3:0]  count_q, count_d;
   logic        upd_valid_q, upd_valid_d;
   logic [31:0] upd_pc_q, upd_pc_d;
   logic        upd_jump_q, upd_jump_d;
   logic [31:0] br_total_q, br_total_d;
   logic [31:0] br_miss_q, br_miss_d;
   logic        push, pop;

   // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
   assign bus.commit_ready = (count_q != 4'd8);
   assign bus.upd_valid    = upd_valid_q;
   assign bus.upd_pc       = upd_pc_q;
   assign bus.upd_jump     = upd_jump_q;
   assign bus.br_total     = br_total_q;
   assign bus.br_miss      = br_miss_q;

   assign push = rdy_in && bus.commit_valid && (count_q != 4'd8);
   assign pop  = rdy_in && (count_q != 4'd0) && !bus.upd_hold;

   always_comb begin
      mem_d       = mem_q;
      head_d      = head_q;
      tail_d      = tail_q;
      upd_valid_d = upd_valid_q;
      upd_pc_d    = upd_pc_q;
      upd_jump_d  = upd_jump_q;
      br_total_d  = br_total_q;
      br_miss_d   = br_miss_q;

      if (rdy_in) begin
         upd_valid_d = 1'b0;
      end
      if (pop) begin
         upd_valid_d = 1'b1;
         upd_pc_d    = mem_q[head_q][32:1];
         upd_jump_d  = mem_q[head_q][0];
         head_d      = head_q + 3'd1;
      end
      if (push) begin
         mem_d[tail_q] = {bus.commit_pc, bus.commit_taken};
         tail_d        = tail_q + 3'd1;
         if (br_total_q != 32'hFFFF_FFFF) begin
            br_total_d = br_total_q + 32'd1;
         end
         if ((bus.commit_taken != bus.commit_pred) && (br_miss_q != 32'hFFFF_FFFF)) begin
            br_miss_d = br_miss_q + 32'd1;
         end
      end
      count_d = count_q + {3'd0, push} - {3'd0, pop};
   end

   // Storage is left uncleared on reset; the pointers alone discard stale records.
   always_ff @(posedge clk_in) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q      <= 3'd0;
         tail_q      <= 3'd0;
         count_q     <= 4'd0;
         upd_valid_q <= 1'b0;
         upd_pc_q    <= 32'd0;
         upd_jump_q  <= 1'b0;
         br_total_q  <= 32'd0;
         br_miss_q   <= 32'd0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         upd_valid_q <= upd_valid_d;
         upd_pc_q    <= upd_pc_d;
         upd_jump_q  <= upd_jump_d;
         br_total_q  <= br_total_d;
         br_miss_q   <= br_miss_d;
      end
   end
endmodule

// File: tb/tb_pred_update_queue.sv
// tb/tb_pred_update_queue.sv - randomized and directed checks of pred_update_queue against a queue model
module tb_pred_update_queue;
   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   pred_update_queue_if bus ();

   pred_update_queue dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   logic [32:0] m_q [$];
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_jump;
   logic [31:0] m_total;
   logic [31:0] m_miss;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the stated rules, then compare after the edge.
   task automatic step(input bit rst, input bit rdy, input bit cv, input logic [31:0] pc,
                       input bit tk, input bit pr, input bit hd);
      logic [32:0] rec;
      bit          do_push;
      rst_in           = rst;
      rdy_in           = rdy;
      bus.commit_valid = cv;
      bus.commit_pc    = pc;
      bus.commit_taken = tk;
      bus.commit_pred  = pr;
      bus.upd_hold     = hd;
      if (rst) begin
         m_q.delete();
         m_valid = 1'b0;
         m_pc    = 32'd0;
         m_jump  = 1'b0;
         m_total = 32'd0;
         m_miss  = 32'd0;
      end else if (rdy) begin
         do_push = cv && (m_q.size() != 8);
         if (m_q.size() > 0 && !hd) begin
            rec     = m_q.pop_front();
            m_valid = 1'b1;
            m_pc    = rec[32:1];
            m_jump  = rec[0];
         end else begin
            m_valid = 1'b0;
         end
         if (do_push) begin
            m_q.push_back({pc, tk});
            if (m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
            if (tk != pr && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
         end
      end
      @(posedge clk_in);
      #1;
      chk("upd_valid", bus.upd_valid, m_valid);
      chk("upd_pc", bus.upd_pc, m_pc);
      chk("upd_jump", bus.upd_jump, m_jump);
      chk("br_total", bus.br_total, m_total);
      chk("br_miss", bus.br_miss, m_miss);
      chk("commit_ready", bus.commit_ready, m_q.size() != 8);
   endtask

   task automatic idle(input bit hd);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, hd);
   endtask

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b0;
      bus.commit_valid = 1'b0;
      bus.commit_pc    = 32'd0;
      bus.commit_taken = 1'b0;
      bus.commit_pred  = 1'b0;
      bus.upd_hold     = 1'b0;

      step(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0);
      chk("reset_ready", bus.commit_ready, 1);
      chk("reset_valid", bus.upd_valid, 0);
      chk("reset_total", bus.br_total, 0);

      // Single push reaches the update port one edge later.
      step(1'b0, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0);
      chk("single_not_early", bus.upd_valid, 0);
      idle(1'b0);
      chk("single_valid", bus.upd_valid, 1);
      chk("single_pc", bus.upd_pc, 32'h1000);
      chk("single_jump", bus.upd_jump, 1);
      chk("single_total", bus.br_total, 1);
      chk("single_miss", bus.br_miss, 1);
      idle(1'b0);
      chk("single_strobe_end", bus.upd_valid, 0);

      // Fill under hold, ninth push dropped, then drain in order.
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b1, 1'b1, 32'(i * 4), i[0], 1'b0, 1'b1);
         if (i == 7) chk("full_ready", bus.commit_ready, 0);
      end
      chk("full_total", bus.br_total, 9);
      for (int i = 0; i < 8; i++) begin
         idle(1'b0);
         chk("drain_order", bus.upd_pc, 32'(i * 4));
      end
      idle(1'b0);
      chk("drain_end", bus.upd_valid, 0);

      // Full queue with pop and push in the same cycle: push refused.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h3333, 1'b1, 1'b0, 1'b0);
      chk("full_pop_ready", bus.commit_ready, 1);
      chk("full_pop_pc", bus.upd_pc, 32'h2000);
      for (int i = 0; i < 8; i++) idle(1'b0);

      // Steady stream exercises pointer wrap.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 32'h4000 + 32'(i * 4), i[1], i[0], 1'b0);
      idle(1'b0);

      // Enable low freezes everything.
      step(1'b0, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h5004, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h6000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);

      // Reset with records queued discards them.
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 32'h7000 + 32'(i * 4), 1'b1, (i >= 3), 1'b1);
      chk("pre_reset_miss", bus.br_miss, 3);
      step(1'b1, 1'b1, 1'b1, 32'h7777, 1'b1, 1'b0, 1'b0);
      chk("rst_total", bus.br_total, 0);
      chk("rst_miss", bus.br_miss, 0);
      chk("rst_ready", bus.commit_ready, 1);
      for (int i = 0; i < 6; i++) begin
         idle(1'b0);
         chk("no_stale", bus.upd_valid, 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 60),
              $urandom, $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 99) < 35));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pred_update_queue.md
PRED_UPDATE_QUEUE -- requirements
Module: pred_update_queue

Interface
REQ-001 SHALL have ports: clk_in  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: rst_in  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: rdy_in  input  1  global enable; when low, all state holds.
REQ-004 SHALL have: commit_valid  input  1  RoB commits a resolved conditional branch this cycle.
REQ-005 SHALL have: commit_pc  input  32  PC of the committed branch.
REQ-006 SHALL have: commit_taken  input  1  actual outcome (1 = taken).
REQ-007 SHALL have: commit_pred  input  1  outcome predicted at fetch.
REQ-008 SHALL have: commit_ready  output  1  queue can accept a record; equals (count != 8), from registered count only.
REQ-009 SHALL have: upd_hold  input  1  predictor table busy; blocks dequeue this cycle.
REQ-010 SHALL have: upd_valid  output  1  registered one-cycle update strobe to predictor (drives rob_valid).
REQ-011 SHALL have: upd_pc  output  32  registered update PC (drives rob_now_pc).
REQ-012 SHALL have: upd_jump  output  1  registered update outcome (drives should_jump).
REQ-013 SHALL have: br_total  output  32  committed-branch counter.
REQ-014 SHALL have: br_miss  output  32  mispredicted-branch counter.

Function
REQ-015 SHALL hold an 8-entry FIFO of {pc[31:0], taken}, 3-bit head/tail pointers wrapping 7->0, 4-bit count 0..8.
REQ-016 Push SHALL occur on a rising edge when rdy_in && commit_valid && commit_ready: entry written at tail, tail+1.
REQ-017 commit_valid while commit_ready low SHALL be dropped: no write, no counter change.
REQ-018 Pop SHALL occur on a rising edge when rdy_in && count>0 && !upd_hold: upd_valid<=1, upd_pc<=head.pc, upd_jump<=head.taken, head+1.
REQ-019 On a rdy_in edge without pop, upd_valid SHALL be 0; upd_pc/upd_jump SHALL hold.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; at count 8 push is refused even if pop occurs (no pass-through).
REQ-021 Latency: record pushed at edge N SHALL appear on upd_valid no earlier than edge N+1 (empty queue, no hold), i.e. visible after edge N+1.
REQ-022 Order SHALL be strict FIFO; at most one pop and one push per cycle.
REQ-023 On accepted push, br_total SHALL increment; br_miss SHALL increment iff commit_taken != commit_pred.
REQ-024 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-025 With rdy_in low, pointers, count, FIFO contents, counters and upd_* SHALL hold; inputs ignored.

Reset
REQ-026 rst_in at an edge SHALL set head=tail=0, count=0, upd_valid=0, upd_pc=0, upd_jump=0, br_total=0, br_miss=0, overriding rdy_in and any push/pop that cycle.
REQ-027 Reset mid-operation SHALL discard all queued records; FIFO storage need not be cleared.
REQ-028 After reset commit_ready SHALL be 1.

Verification
REQ-029 Single push pc=0x1000, taken=1, pred=0, hold=0 -> next edge upd_valid=1, upd_pc=0x1000, upd_jump=1; br_total=1, br_miss=1; following edge upd_valid=0.
REQ-030 upd_hold=1, push 8 records pc=0x0,0x4..0x1C -> commit_ready=0; 9th push dropped, br_total=8; release hold -> 8 consecutive strobes in order 0x0..0x1C, then upd_valid=0.
REQ-031 Full queue, hold=0, commit_valid=1 same cycle -> pop occurs, push refused, count=7, commit_ready=1 next cycle.
REQ-032 Steady stream 20 pushes, one per cycle, hold=0 -> 20 strobes, each one edge after its push, count never >1, pointers wrap correctly.
REQ-033 rdy_in=0 for 3 cycles with 2 entries queued and commit_valid=1 -> no state change; rdy_in=1 resumes identically.
REQ-034 rst_in asserted with 5 entries queued and br_miss=3 -> next edge count=0, counters 0, upd_valid=0, commit_ready=1; no stale strobes afterward.
